// File: rtl/pl_instruction_fetch.sv
`default_nettype none
// =============================================================================
// Module      : pl_instruction_fetch
// Description : Pipelined instruction fetch with PC redirect and decoupling FIFO.
// Revision    : 1.0 - initial release
// =============================================================================
module pl_instruction_fetch #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              FIFO_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      branch,
   input  logic [XLEN-1:0] pc_adder_result,
   input  logic [XLEN-1:0] alu_result,
   output logic            rom_en,
   output logic [XLEN-1:0] rom_addr,
   input  logic [31:0]     rom_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_next,
   output logic [31:0]     out_instruction,
   output logic            out_misaligned
);

   localparam int          c_PTR_W    = $clog2(FIFO_DEPTH);
   localparam int          c_CNT_W    = c_PTR_W + 1;
   localparam logic [31:0] c_NOP_INSN = 32'h0000_0013;

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
   logic                 inflight_q, inflight_d;
   logic [XLEN-1:0]      inflight_pc_q, inflight_pc_d;
   logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [c_CNT_W-1:0]   count_q, count_d;

   logic [XLEN-1:0]      mem_pc_q   [FIFO_DEPTH];
   logic [31:0]          mem_insn_q [FIFO_DEPTH];
   logic                 mem_mis_q  [FIFO_DEPTH];

   logic                 w_redirect;
   logic [XLEN-1:0]      w_target;
   logic                 w_target_mis;
   logic                 w_valid;
   logic                 w_pop;
   logic                 w_enq;
   logic                 w_issue;
   logic [c_CNT_W-1:0]   w_occ;

   assign w_redirect   = (branch == 2'd1) || (branch == 2'd2);
   assign w_target     = (branch == 2'd1) ? pc_adder_result : (alu_result & ~XLEN'(1));
   assign w_target_mis = (w_target[1:0] != 2'b00);
   assign w_valid      = !rst && (count_q != '0);
   assign w_pop        = w_valid && out_ready;
   assign w_enq        = inflight_q && !w_redirect;
   // Counting the pop lets a full buffer keep streaming at one fetch per cycle.
   assign w_occ        = count_q + c_CNT_W'(inflight_q) - c_CNT_W'(w_pop);
   assign w_issue      = (state_q == S_RUN) && !rst && !w_redirect
                         && (w_occ < c_CNT_W'(FIFO_DEPTH));

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      if (w_redirect) begin
         fetch_pc_d = w_target;
         rd_ptr_d   = '0;
         if (w_target_mis) begin
            state_d  = S_HALT;
            wr_ptr_d = c_PTR_W'(1);
            count_d  = c_CNT_W'(1);
         end else begin
            state_d  = S_RUN;
            wr_ptr_d = '0;
            count_d  = '0;
         end
      end else begin
         if (w_issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
         end
         if (w_enq) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
         if (w_pop) rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
         count_d = count_q + c_CNT_W'(w_enq) - c_CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_RUN;
         fetch_pc_q    <= RESET_VECTOR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // The misaligned marker lands in slot 0 because the flush rewinds both pointers.
   always_ff @(posedge clk) begin
      if (w_redirect && w_target_mis) begin
         mem_pc_q[0]   <= w_target;
         mem_insn_q[0] <= c_NOP_INSN;
         mem_mis_q[0]  <= 1'b1;
      end else if (w_enq) begin
         mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
         mem_insn_q[wr_ptr_q] <= rom_data;
         mem_mis_q[wr_ptr_q]  <= 1'b0;
      end
   end

   assign rom_en          = w_issue;
   assign rom_addr        = fetch_pc_q;
   assign out_valid       = w_valid;
   assign out_pc          = mem_pc_q[rd_ptr_q];
   assign out_pc_next     = mem_pc_q[rd_ptr_q] + XLEN'(4);
   assign out_instruction = mem_insn_q[rd_ptr_q];
   assign out_misaligned  = w_valid && mem_mis_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: doc/pl_instruction_fetch.md
PL_INSTRUCTION_FETCH -- requirements
Module: pl_instruction_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/data width.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, first fetch address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, fetch-buffer entries (power of 2, >=2).
REQ-004 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: branch  in  2  PC mux select: 0 NOP, 1 PC_ADDER, 2 ALU_OUT, 3 reserved (treated as NOP).
REQ-007 SHALL have ports: pc_adder_result  in  XLEN  branch target; alu_result  in  XLEN  jump target.
REQ-008 SHALL have ports: rom_en  out  1  read strobe; rom_addr  out  XLEN  byte address; rom_data  in  32  read data, valid the cycle after rom_en.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_pc  out  XLEN; out_pc_next  out  XLEN; out_instruction  out  32; out_misaligned  out  1.

Function
REQ-010 SHALL hold fetch_pc and a two-state FSM: RUN, HALT.
REQ-011 Issue in cycle N SHALL occur iff state=RUN, rst=0, no redirect in N, and occupancy + inflight - pop < FIFO_DEPTH; issue drives rom_en=1, rom_addr=fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^XLEN).
REQ-012 rom_data for an issue in N SHALL be enqueued at the edge ending N+1, tagged with its pc, unless squashed.
REQ-013 Redirect SHALL be branch in {1,2}; target = pc_adder_result (1) or alu_result with bit0 cleared (2).
REQ-014 Redirect in cycle N SHALL flush all buffered entries except one handed off in N, squash any in-flight read, and load fetch_pc <= target; no issue in N.
REQ-015 Redirect with target[1:0] != 0 SHALL enqueue one entry {pc=target, instruction=32'h00000013, misaligned=1}, issue nothing further, and move to HALT.
REQ-016 HALT SHALL exit to RUN only on an aligned redirect; a misaligned redirect in HALT SHALL repeat REQ-015.
REQ-017 out_* SHALL reflect buffer head; out_pc_next = out_pc+4 (mod 2^XLEN); out_misaligned=0 for normal entries.
REQ-018 Pop SHALL occur iff out_valid && out_ready; while out_valid && !out_ready, all out_* SHALL hold stable.
REQ-019 Buffer SHALL never overflow; out_valid=0 when empty.
REQ-020 Latency: issue in N -> out_valid in N+2 (if buffer empty); redirect in N -> first target entry out_valid in N+3.
REQ-021 With out_ready held 1 and no redirect, throughput SHALL be one instruction per cycle for any FIFO_DEPTH>=2.
REQ-022 Simultaneous enqueue and pop in one cycle SHALL both take effect; occupancy unchanged.
REQ-023 Reserved branch=3 SHALL have no effect.

Reset
REQ-024 While rst=1: fetch_pc=RESET_VECTOR, state=RUN, buffer empty, inflight cleared, rom_en=0, out_valid=0, out_misaligned=0.
REQ-025 rst asserted mid-operation SHALL discard in-flight reads and buffered entries at the next edge.
REQ-026 First cycle with rst=0 SHALL issue RESET_VECTOR; out_valid first high two cycles later.

Verification
REQ-027 Reset release, out_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles, out_pc_next=out_pc+4, out_instruction = ROM[out_pc].
REQ-028 branch=1, pc_adder_result=128 for one cycle -> after flushed entries, next out_pc=128, then 132; no stale pcs delivered.
REQ-029 branch=2, alu_result=193 -> next out_pc=192, then 196.
REQ-030 out_ready=0 for 6 cycles after reset -> at most FIFO_DEPTH entries buffered, rom_en stops, out_* stable; on release pcs 0,4,8,... with no gaps or duplicates.
REQ-031 branch=1, pc_adder_result=130 -> one entry pc=130, instruction=0x00000013, misaligned=1, then out_valid=0 and rom_en=0 until branch=1 target 256 -> out_pc=256.
REQ-032 rst=1 for one cycle during steady streaming -> out_valid=0 next cycle, fetch restarts at 0.
